// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pipe_pkg: immediate-select encoding and funct3 constants shared with the control unit
package imm_gen_pipe_pkg;
  localparam int SEL_W = 3;
  typedef enum logic [SEL_W-1:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_R, IMM_L, IMM_RSVD
  } imm_sel_e;
  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SRX = 3'b101;
endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: valid/ready beat bus between decode and the immediate pipeline
interface imm_gen_pipe_if #(
  parameter int XLEN = 32,
  parameter int LANES = 1,
  parameter int TAG_W = 8
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [LANES*32-1:0] in_instr;
  logic [LANES*3-1:0] in_imm_sel;
  logic [TAG_W-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [LANES*XLEN-1:0] out_imm;
  logic [LANES-1:0] out_sel_err;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output flush, in_valid, in_instr, in_imm_sel, in_tag, out_ready,
    input in_ready, out_valid, out_imm, out_sel_err, out_tag
  );
  modport slave (
    input flush, in_valid, in_instr, in_imm_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_sel_err, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe_lane_dec.sv
// imm_gen_pipe_lane_dec: combinational RISC-V immediate extraction for one instruction word
module imm_gen_pipe_lane_dec
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] instr,
  input  logic [SEL_W-1:0] sel,
  output logic [XLEN-1:0] imm,
  output logic err
);
  localparam int SHW = $clog2(XLEN);
  logic shift;
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];
  always_comb begin
    shift = instr[14:12] == FUNCT3_SLL || instr[14:12] == FUNCT3_SRX;
    err = imm_sel_e'(sel) == IMM_RSVD;
    // signed casts widen by sign extension, so XLEN=64 replicates bit 31 for free
    case (imm_sel_e'(sel))
      IMM_I: imm = shift ? XLEN'(instr[20 +: SHW]) : XLEN'($signed(instr[31:20]));
      IMM_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_L: imm = XLEN'($signed(instr[31:20]));
      default: imm = '0;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered multi-lane immediate generator with a one-entry skid buffer
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LANES = 1,
  parameter int TAG_W = 8
) (
  input logic clk,
  input logic rst,
  imm_gen_pipe_if.slave bus
);
  logic [LANES*XLEN-1:0] dec_imm, skid_imm;
  logic [LANES-1:0] dec_err, skid_err;
  logic [TAG_W-1:0] skid_tag;
  logic skid_valid, acc, drain, skid_n;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    imm_gen_pipe_lane_dec #(.XLEN(XLEN)) u_dec (
      .instr(bus.in_instr[32*i +: 32]),
      .sel(bus.in_imm_sel[SEL_W*i +: SEL_W]),
      .imm(dec_imm[XLEN*i +: XLEN]),
      .err(dec_err[i])
    );
  end
  always_comb begin
    acc = bus.in_valid & bus.in_ready;
    drain = !bus.out_valid | bus.out_ready;
    skid_n = !bus.flush & !drain & (skid_valid | acc);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.in_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_imm <= '0;
      bus.out_sel_err <= '0;
      bus.out_tag <= '0;
      skid_valid <= 1'b0;
      skid_imm <= '0;
      skid_err <= '0;
      skid_tag <= '0;
    end else begin
      bus.in_ready <= !skid_n;
      skid_valid <= skid_n;
      bus.out_valid <= !bus.flush & (drain ? skid_valid | acc : 1'b1);
      // skid is only ever full while in_ready is low, so it never races a new accept
      if (!bus.flush & drain & (skid_valid | acc)) begin
        bus.out_imm <= skid_valid ? skid_imm : dec_imm;
        bus.out_sel_err <= skid_valid ? skid_err : dec_err;
        bus.out_tag <= skid_valid ? skid_tag : bus.in_tag;
      end
      if (!drain & acc) begin
        skid_imm <= dec_imm;
        skid_err <= dec_err;
        skid_tag <= bus.in_tag;
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vectors against a 32-bit and a 64-bit two-lane instance in lockstep
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v_in = 1'b0, v_ordy = 1'b0, v_flush = 1'b0;
  logic [63:0] v_instr = '0;
  logic [5:0] v_sel = '0;
  logic [7:0] v_tag = '0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  imm_gen_pipe_if #(.XLEN(32), .LANES(2), .TAG_W(8)) i32 ();
  imm_gen_pipe_if #(.XLEN(64), .LANES(2), .TAG_W(8)) i64 ();
  assign i32.flush = v_flush;
  assign i32.in_valid = v_in;
  assign i32.in_instr = v_instr;
  assign i32.in_imm_sel = v_sel;
  assign i32.in_tag = v_tag;
  assign i32.out_ready = v_ordy;
  assign i64.flush = v_flush;
  assign i64.in_valid = v_in;
  assign i64.in_instr = v_instr;
  assign i64.in_imm_sel = v_sel;
  assign i64.in_tag = v_tag;
  assign i64.out_ready = v_ordy;
  imm_gen_pipe #(.XLEN(32), .LANES(2), .TAG_W(8)) dut32 (.clk(clk), .rst(rst), .bus(i32.slave));
  imm_gen_pipe #(.XLEN(64), .LANES(2), .TAG_W(8)) dut64 (.clk(clk), .rst(rst), .bus(i64.slave));

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] i0, input logic [2:0] s0, input logic [31:0] i1,
                      input logic [2:0] s1, input logic [7:0] t);
    v_in = 1'b1;
    v_instr = {i1, i0};
    v_sel = {s1, s0};
    v_tag = t;
  endtask

  task automatic exp_idle(input string n, input logic rdy);
    chk({n, ".valid32"}, 128'(i32.out_valid), 128'(1'b0));
    chk({n, ".valid64"}, 128'(i64.out_valid), 128'(1'b0));
    chk({n, ".ready32"}, 128'(i32.in_ready), 128'(rdy));
    chk({n, ".ready64"}, 128'(i64.in_ready), 128'(rdy));
  endtask

  task automatic exp_zero(input string n);
    chk({n, ".imm32"}, 128'(i32.out_imm), 128'(0));
    chk({n, ".imm64"}, 128'(i64.out_imm), 128'(0));
    chk({n, ".err32"}, 128'(i32.out_sel_err), 128'(0));
    chk({n, ".err64"}, 128'(i64.out_sel_err), 128'(0));
    chk({n, ".tag32"}, 128'(i32.out_tag), 128'(0));
    chk({n, ".tag64"}, 128'(i64.out_tag), 128'(0));
  endtask

  task automatic exp_out(input string n, input logic rdy, input logic [7:0] t, input logic [1:0] e,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [63:0] b0, input logic [63:0] b1);
    chk({n, ".valid32"}, 128'(i32.out_valid), 128'(1'b1));
    chk({n, ".valid64"}, 128'(i64.out_valid), 128'(1'b1));
    chk({n, ".ready32"}, 128'(i32.in_ready), 128'(rdy));
    chk({n, ".ready64"}, 128'(i64.in_ready), 128'(rdy));
    chk({n, ".tag32"}, 128'(i32.out_tag), 128'(t));
    chk({n, ".tag64"}, 128'(i64.out_tag), 128'(t));
    chk({n, ".err32"}, 128'(i32.out_sel_err), 128'(e));
    chk({n, ".err64"}, 128'(i64.out_sel_err), 128'(e));
    chk({n, ".imm32"}, 128'(i32.out_imm), 128'({a1, a0}));
    chk({n, ".imm64"}, 128'(i64.out_imm), {b1, b0});
  endtask

  initial begin
    step();
    step();
    exp_idle("rst", 1'b0);
    exp_zero("rst");
    rst = 1'b0;
    step();
    exp_idle("post_rst", 1'b1);
    // back-to-back decode, consumer always ready
    v_ordy = 1'b1;
    beat(32'hFFF00093, 3'd0, 32'h4050D093, 3'd0, 8'h11);
    step();
    exp_out("addi_srai", 1'b1, 8'h11, 2'b00, 32'hFFFFFFFF, 32'h00000005,
            64'hFFFFFFFFFFFFFFFF, 64'h5);
    beat(32'hFE000EE3, 3'd2, 32'h800000B7, 3'd3, 8'h22);
    step();
    exp_out("beq_lui", 1'b1, 8'h22, 2'b00, 32'hFFFFFFFC, 32'h80000000,
            64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000);
    beat(32'h123450B7, 3'd3, 32'hFE20AC23, 3'd1, 8'h33);
    step();
    exp_out("lui_sw", 1'b1, 8'h33, 2'b00, 32'h12345000, 32'hFFFFFFF8,
            64'h12345000, 64'hFFFFFFFFFFFFFFF8);
    beat(32'hFFDFF06F, 3'd4, 32'h03F09093, 3'd0, 8'h44);
    step();
    exp_out("jal_slli", 1'b1, 8'h44, 2'b00, 32'hFFFFFFFC, 32'h0000001F,
            64'hFFFFFFFFFFFFFFFC, 64'h3F);
    beat(32'h4050D093, 3'd6, 32'hFFFFFFFF, 3'd7, 8'h55);
    step();
    exp_out("load_rsvd", 1'b1, 8'h55, 2'b10, 32'h00000405, 32'h0, 64'h405, 64'h0);
    beat(32'hFFFFFFFF, 3'd5, 32'hFFF00093, 3'd6, 8'h66);
    step();
    exp_out("r_load", 1'b1, 8'h66, 2'b00, 32'h0, 32'hFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF);
    v_in = 1'b0;
    step();
    exp_idle("drained", 1'b1);
    // three stalled cycles with in_valid held: output + skid fill, then drain in order
    v_ordy = 1'b0;
    beat(32'h00100093, 3'd0, 32'h7FF00093, 3'd0, 8'hA1);
    step();
    exp_out("stall_t1", 1'b1, 8'hA1, 2'b00, 32'h1, 32'h7FF, 64'h1, 64'h7FF);
    beat(32'h80000093, 3'd0, 32'h12300093, 3'd0, 8'hA2);
    step();
    exp_out("stall_hold1", 1'b0, 8'hA1, 2'b00, 32'h1, 32'h7FF, 64'h1, 64'h7FF);
    beat(32'h45600093, 3'd0, 32'hABC00093, 3'd0, 8'hA3);
    step();
    exp_out("stall_hold2", 1'b0, 8'hA1, 2'b00, 32'h1, 32'h7FF, 64'h1, 64'h7FF);
    v_ordy = 1'b1;
    step();
    exp_out("skid_t2", 1'b1, 8'hA2, 2'b00, 32'hFFFFF800, 32'h123,
            64'hFFFFFFFFFFFFF800, 64'h123);
    step();
    exp_out("accept_t3", 1'b1, 8'hA3, 2'b00, 32'h456, 32'hFFFFFABC,
            64'h456, 64'hFFFFFFFFFFFFFABC);
    v_in = 1'b0;
    step();
    exp_idle("stall_done", 1'b1);
    // flush with output and skid both full
    v_ordy = 1'b0;
    beat(32'h00500093, 3'd0, 32'h00600093, 3'd0, 8'hB1);
    step();
    beat(32'h00700093, 3'd0, 32'h00800093, 3'd0, 8'hB2);
    step();
    chk("flush_pre.ready32", 128'(i32.in_ready), 128'(1'b0));
    beat(32'h00900093, 3'd0, 32'h00A00093, 3'd0, 8'hB3);
    v_flush = 1'b1;
    step();
    exp_idle("flush_full", 1'b1);
    v_flush = 1'b0;
    v_in = 1'b0;
    v_ordy = 1'b1;
    step();
    exp_idle("flush_no_stale", 1'b1);
    // beat offered during flush while ready is dropped
    beat(32'h00B00093, 3'd0, 32'h00C00093, 3'd0, 8'hB4);
    v_flush = 1'b1;
    step();
    exp_idle("flush_drop", 1'b1);
    v_flush = 1'b0;
    v_in = 1'b0;
    step();
    exp_idle("flush_drop2", 1'b1);
    // reset in the middle of a stall
    v_ordy = 1'b0;
    beat(32'h00100093, 3'd0, 32'hFFFFFFFF, 3'd7, 8'hC1);
    step();
    exp_out("pre_rst", 1'b1, 8'hC1, 2'b10, 32'h1, 32'h0, 64'h1, 64'h0);
    beat(32'h00200093, 3'd0, 32'h00300093, 3'd0, 8'hC2);
    step();
    rst = 1'b1;
    v_in = 1'b0;
    step();
    exp_idle("mid_rst", 1'b0);
    exp_zero("mid_rst");
    rst = 1'b0;
    step();
    exp_idle("after_rst", 1'b1);
    v_ordy = 1'b1;
    step();
    exp_idle("after_rst_no_skid", 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
